mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter between the instruction cache and the two-way data cache. It multiplexes icache word fetches and dcache two-word block fills and writebacks onto the one RAM port. The dcache gets priority and a burst lock so its block transfers complete back-to-back. A starvation counter bounds how long instruction fetch can be held off.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive dcache grants, each made while iREN is high, after which the icache wins the next arbitration.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly the cycle iload is valid.
- iload  out  32  fetched instruction word.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins if asserted together with dREN.
- daddr  in  32  dcache word address; bit 2 is the block offset.
- dstore  in  32  dcache write data.
- dwait  out  1  low for exactly the cycle a dcache access completes.
- dload  out  32  dcache read data.
- ramREN, ramWEN  out  1 each  RAM enables.
- ramaddr  out  32  RAM word address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE/BUSY/ACCESS/ERROR.
- err  out  1  sticky flag; set when ramstate is ERROR.

## Operation
States: IDLE, ISERVE, DSERVE.

IDLE:
- RAM enables are 0. iwait and dwait are 1.
- If dREN or dWEN, and (starve < STARVE_LIMIT or !iREN): next state is DSERVE. If iREN is also high, starve increments.
- Else if iREN: next state is ISERVE and starve clears.

ISERVE:
- ramREN = iREN, ramaddr = iaddr.
- On ramstate == ACCESS: iwait = 0, next state is IDLE.
- If iREN drops before completion: next state is IDLE and no completion is signalled.

DSERVE:
- ramREN = dREN & !dWEN, ramWEN = dWEN, ramaddr = daddr, ramstore = dstore.
- On ACCESS: dwait = 0.
  - If daddr[2] == 0, stay in DSERVE (burst lock; the second word follows with no dead cycle). Starve does not increment.
  - Else go to IDLE.
- If both dREN and dWEN are low in DSERVE, next state is IDLE.

Data return:
- iload = ramload and dload = ramload, both combinational, always driven.

Errors:
- ramstate == ERROR: hold the requester's wait at 1, set err, stay in the state.
- err clears only on RST.

Counter:
- starve saturates at STARVE_LIMIT.
- Width is $clog2(STARVE_LIMIT+1).

## Timing
- Reset values: state IDLE, starve 0, err 0, iwait 1, dwait 1, ramREN 0, ramWEN 0, ramaddr 0, ramstore 0.
- Reset asserted mid-transaction aborts it: enables are 0 on the next edge and no wait pulse is emitted.
- Latency:
  - Request seen in IDLE at cycle k produces a RAM enable at k+1.
  - With an immediate ACCESS, the wait goes low at k+1.
  - Each non-burst access is followed by one IDLE cycle.
  - A block transfer is two words with no gap between them.
- All outputs other than iload/dload are decoded combinationally from state and inputs. Registers are state, starve and err only.
- The wait pulse is exactly one cycle wide per word.
- Requesters must hold address, data and enables stable until their wait goes low.
- An iREN arriving while in DSERVE waits; it is never granted mid-burst.

## Structure
- cpu_types_pkg supplies word_t and ramstate_t, and holds the new arbstate_t enum (IDLE/ISERVE/DSERVE).
- Sub-module arb_starve_counter, with inputs inc/clr/limit and output at_limit, isolates the saturating counter.
- Everything else is one module with an always_ff for registers and an always_comb for next-state and outputs.

## Test plan
- Reset: hold RST 2 cycles with all requests high -> iwait=dwait=1, ramREN=ramWEN=0, err=0 throughout reset.
- Icache only: iREN=1, iaddr=0x40, ramstate ACCESS on first enabled cycle, ramload=0xDEADBEEF -> ramREN at k+1, iwait=0 and iload=0xDEADBEEF at k+1, IDLE at k+2.
- Dcache burst: dREN with daddr=0x100 then 0x104, ACCESS each cycle -> two consecutive dwait=0 pulses with no IDLE between; concurrent iREN is granted only after the second word.
- Writeback: dWEN=1, dstore=0x12345678, daddr=0x204, two BUSY cycles then ACCESS -> ramWEN held 3 cycles, ramstore=0x12345678, dwait low only on the third cycle.
- Starvation: iREN held high while dcache issues 5 single-word reads at blkoff 1 -> icache is granted after the 4th dcache grant and starve returns to 0.
- Error/abort: ramstate=ERROR during DSERVE -> err=1 and dwait stays 1; drop dREN -> IDLE next cycle and err stays 1 until RST.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM handshake state and arbiter state.
package cpu_types_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLKOFF_BIT = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISERVE = 2'd1,
    DSERVE = 2'd2
  } arbstate_t;

endpackage : cpu_types_pkg

// File: rtl/arb_starve_counter.sv
// Saturating count of dcache grants made while the icache was waiting.
module arb_starve_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         at_limit_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < limit_i)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit_o = (count_q >= limit_i);

endmodule : arb_starve_counter

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: dcache priority with block-burst lock, icache
// starvation bound, sticky RAM error flag.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arbstate_t state_q;
  arbstate_t state_d;
  logic      err_q;
  logic      err_d;
  logic      starve_inc;
  logic      starve_clr;
  logic      starve_at_limit;

  arb_starve_counter #(
    .W(STARVE_W)
  ) u_starve (
    .clk_i      (CLK),
    .rst_i      (RST),
    .inc_i      (starve_inc),
    .clr_i      (starve_clr),
    .limit_i    (STARVE_W'(STARVE_LIMIT)),
    .at_limit_o (starve_at_limit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced idle while RST is high so an aborted access never pulses a wait.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q | (ramstate == ERROR);
    iwait      = 1'b1;
    dwait      = 1'b1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;

    if (!RST) begin
      case (state_q)
        IDLE: begin
          if ((dREN || dWEN) && (!starve_at_limit || !iREN)) begin
            state_d    = DSERVE;
            starve_inc = iREN;
          end else if (iREN) begin
            state_d    = ISERVE;
            starve_clr = 1'b1;
          end
        end

        ISERVE: begin
          ramREN  = iREN;
          ramaddr = iaddr;
          if (!iREN) begin
            state_d = IDLE;
          end else if (ramstate == ACCESS) begin
            iwait   = 1'b0;
            state_d = IDLE;
          end
        end

        DSERVE: begin
          ramREN   = dREN & ~dWEN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (!dREN && !dWEN) begin
            state_d = IDLE;
          end else if (ramstate == ACCESS) begin
            dwait = 1'b0;
            // First word of a block keeps the lock so the second follows back-to-back.
            if (daddr[BLKOFF_BIT]) begin
              state_d = IDLE;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign iload = ramload;
  assign dload = ramload;
  assign err   = err_q;

endmodule : mem_arbiter
